// File: rtl/constant_add_seq.sv
// Sequential Ascon constant-addition engine: iterates pa/pb rounds over a 320-bit state.
// Optional CONST_ADD_BYPASS_EN adds bypass_i, which suppresses the constant while keeping timing.
module constant_add_seq #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6,
  parameter int ADD_LANE  = 2
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic         hold_i,
`ifdef CONST_ADD_BYPASS_EN
  input  logic         bypass_i,
`endif
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic [3:0]   round_o,
  output logic [7:0]   constant_o,
  output logic         busy_o,
  output logic         done_o
);

  if (PA_ROUNDS < 1 || PA_ROUNDS > 12) begin : g_bad_pa
    $error("constant_add_seq: PA_ROUNDS must be in 1..12");
  end
  if (PB_ROUNDS < 1 || PB_ROUNDS > 12) begin : g_bad_pb
    $error("constant_add_seq: PB_ROUNDS must be in 1..12");
  end
  if (ADD_LANE < 0 || ADD_LANE > 4) begin : g_bad_lane
    $error("constant_add_seq: ADD_LANE must be in 0..4");
  end

  // Lane k of the 320-bit state occupies bits [64k+63:64k]
  localparam int          LO      = 64 * ADD_LANE;
  localparam logic [3:0]  START_A = 4'(12 - PA_ROUNDS);
  localparam logic [3:0]  START_B = 4'(12 - PB_ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q;
  logic [319:0] state_q;
  logic [3:0]   r_q;
  logic [7:0]   rc;
  logic         byp;

`ifdef CONST_ADD_BYPASS_EN
  assign byp = bypass_i;
`else
  assign byp = 1'b0;
`endif

  assign rc = byp ? 8'h00 : {4'hF - r_q, r_q};

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      r_q     <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (start_i) begin
          state_q <= state_i;
          r_q     <= mode_i ? START_B : START_A;
          fsm_q   <= RUN;
        end
        RUN: if (!hold_i) begin
          state_q[LO +: 8] <= state_q[LO +: 8] ^ rc;
          if (r_q == 4'd11) fsm_q <= DONE;
          else              r_q   <= r_q + 4'd1;
        end
        DONE: begin
          r_q   <= '0;
          fsm_q <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from registers; only constant_o sees bypass_i
  assign state_o    = state_q;
  assign round_o    = (fsm_q == RUN) ? r_q : 4'd0;
  assign constant_o = (fsm_q == RUN) ? rc  : 8'h00;
  assign busy_o     = (fsm_q == RUN) || (fsm_q == DONE);
  assign done_o     = (fsm_q == DONE);

endmodule

// File: tb/tb_constant_add_seq.sv
// Randomized self-checking bench for constant_add_seq against a lane-level reference model.
module tb_constant_add_seq;
  logic         clk = 1'b0;
  logic         reset_i = 1'b1, start_i = 1'b0, mode_i = 1'b0, hold_i = 1'b0;
  logic [319:0] state_i = '0;
  logic [319:0] state_o;
  logic [3:0]   round_o;
  logic [7:0]   constant_o;
  logic         busy_o, done_o;
`ifdef CONST_ADD_BYPASS_EN
  logic         bypass_i = 1'b0;
`endif

  int checks = 0, errors = 0;

  // Observations collected by do_op
  int           obs_r[$], obs_c[$], exp_r[$], exp_c[$];
  int           lat;
  logic [319:0] fin, post;
  logic         hold_changed, done_next, busy_next;

  constant_add_seq #(.PA_ROUNDS(12), .PB_ROUNDS(6), .ADD_LANE(2)) dut (
    .clock_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i), .hold_i(hold_i),
`ifdef CONST_ADD_BYPASS_EN
    .bypass_i(bypass_i),
`endif
    .state_i(state_i), .state_o(state_o), .round_o(round_o), .constant_o(constant_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic int nrounds(input logic m);
    return m ? 6 : 12;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference: treat the state as five 64-bit lanes, XOR each round's constant into lane 2's low byte
  function automatic logic [319:0] ref_final(input logic m, input logic [319:0] st, input logic byp);
    logic [63:0]  ln[5];
    logic [319:0] res;
    for (int k = 0; k < 5; k++) ln[k] = st[64*k +: 64];
    for (int r = 12 - nrounds(m); r < 12; r++)
      if (!byp) ln[2][7:0] = ln[2][7:0] ^ 8'(((15 - r) << 4) | r);
    for (int k = 0; k < 5; k++) res[64*k +: 64] = ln[k];
    return res;
  endfunction

  task automatic build_exp(input logic m, input int hr, input int hl, input logic byp);
    exp_r.delete(); exp_c.delete();
    for (int r = 12 - nrounds(m); r < 12; r++)
      for (int j = 0; j <= ((r == hr) ? hl : 0); j++) begin
        exp_r.push_back(r);
        exp_c.push_back(byp ? 0 : (((15 - r) << 4) | r));
      end
  endtask

  function automatic int first_diff(input int a[$], input int b[$]);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < a.size(); i++) if (a[i] != b[i]) return i;
    return -1;
  endfunction

  // Drives one operation (called just after a negedge); records what the DUT did
  task automatic do_op(input logic m, input logic [319:0] st, input int hr, input int hl,
                       input logic byp, input logic spam);
    int held = 0;
    logic [319:0] snap = '0;
    obs_r.delete(); obs_c.delete(); lat = -1; hold_changed = 1'b0; fin = '0;
    state_i = st; mode_i = m; start_i = 1'b1;
`ifdef CONST_ADD_BYPASS_EN
    bypass_i = byp;
`endif
    @(posedge clk);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (spam) begin start_i = 1'b1; state_i = rand320(); mode_i = ~m; end
      else start_i = 1'b0;
      if (done_o) begin lat = k; fin = state_o; break; end
      if (busy_o) begin obs_r.push_back(int'(round_o)); obs_c.push_back(int'(constant_o)); end
      if (hold_i && state_o !== snap) hold_changed = 1'b1;
      if (busy_o && int'(round_o) == hr && held < hl) begin
        if (!hold_i) snap = state_o;
        hold_i = 1'b1; held++;
      end else hold_i = 1'b0;
    end
    hold_i = 1'b0;
    @(negedge clk);
    done_next = done_o; busy_next = busy_o; post = state_o;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (state_o !== '0 || round_o !== 4'd0 || constant_o !== 8'h00 || busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b round=%0d const=%h state_nz=%b, required all zero",
               busy_o, done_o, round_o, constant_o, |state_o);
    end
    reset_i = 1'b0;
    state_i = rand320(); mode_i = 1'b0; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    repeat (4) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || state_o !== '0 || round_o !== 4'd0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b round=%0d state_nz=%b, required 0/0/0/0",
               busy_o, done_o, round_o, |state_o);
    end
    reset_i = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < 20; k++) begin @(negedge clk); if (done_o || busy_o) seen++; end
      checks++;
      if (seen != 0) begin
        errors++;
        $display("FAIL reset_abort: busy/done seen in %0d cycles after reset, required 0", seen);
      end
    end
  endtask

  task automatic test_pa();
    int d;
    do_op(1'b0, '0, -1, 0, 1'b0, 1'b0);
    build_exp(1'b0, -1, 0, 1'b0);
    checks++; d = first_diff(obs_r, exp_r);
    if (d >= 0) begin errors++; $display("FAIL pa_rounds: index %0d differs (got %0d entries, required %0d)", d, obs_r.size(), exp_r.size()); end
    checks++; d = first_diff(obs_c, exp_c);
    if (d >= 0) begin errors++; $display("FAIL pa_consts: index %0d differs (got %0d entries, required %0d)", d, obs_c.size(), exp_c.size()); end
    checks++;
    if (lat != 13) begin errors++; $display("FAIL pa_latency: got %0d, required 13", lat); end
    checks++;
    if (fin !== '0) begin errors++; $display("FAIL pa_state: got %h, required 0", fin); end
    checks++;
    if (done_next !== 1'b0 || busy_next !== 1'b0 || post !== fin) begin
      errors++; $display("FAIL pa_after_done: done=%b busy=%b held=%b, required 0/0/1", done_next, busy_next, post === fin);
    end
  endtask

  task automatic test_pb();
    do_op(1'b1, '0, -1, 0, 1'b0, 1'b0);
    checks++;
    if (obs_r.size() < 1 || obs_r[0] != 6 || obs_c[0] != 'h96) begin
      errors++; $display("FAIL pb_first_round: got round %0d const %0h, required 6/96",
                         obs_r.size() ? obs_r[0] : -1, obs_c.size() ? obs_c[0] : -1);
    end
    checks++;
    if (lat != 7) begin errors++; $display("FAIL pb_latency: got %0d, required 7", lat); end
    checks++;
    if (fin !== (320'h11 << 128)) begin errors++; $display("FAIL pb_state: got %h, required lane2 byte 11", fin); end
  endtask

  task automatic test_hold();
    int d;
    do_op(1'b1, '0, 8, 3, 1'b0, 1'b0);
    build_exp(1'b1, 8, 3, 1'b0);
    checks++; d = first_diff(obs_r, exp_r);
    if (d >= 0) begin errors++; $display("FAIL hold_rounds: index %0d differs (got %0d entries, required %0d)", d, obs_r.size(), exp_r.size()); end
    checks++;
    if (hold_changed) begin errors++; $display("FAIL hold_frozen: state changed during hold, required unchanged"); end
    checks++;
    if (lat != 10) begin errors++; $display("FAIL hold_latency: got %0d, required 10", lat); end
    checks++;
    if (fin !== (320'h11 << 128)) begin errors++; $display("FAIL hold_state: got %h, required lane2 byte 11", fin); end
  endtask

  task automatic test_start_ignored();
    logic [319:0] s1, s2;
    s1 = rand320(); s2 = rand320();
    do_op(1'b1, s1, -1, 0, 1'b0, 1'b1);
    checks++;
    if (fin !== ref_final(1'b1, s1, 1'b0) || lat != 7) begin
      errors++; $display("FAIL start_ignored: latency %0d state %h, required 7 / %h", lat, fin, ref_final(1'b1, s1, 1'b0));
    end
    checks++;
    if (busy_next !== 1'b0) begin errors++; $display("FAIL start_in_done: busy=%b after done, required 0", busy_next); end
    do_op(1'b0, s2, -1, 0, 1'b0, 1'b0);
    checks++;
    if (fin !== ref_final(1'b0, s2, 1'b0) || lat != 13) begin
      errors++; $display("FAIL back_to_back: latency %0d state %h, required 13 / %h", lat, fin, ref_final(1'b0, s2, 1'b0));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic m; logic [319:0] st; int hr, hl, d;
      m  = 1'($urandom);
      st = rand320();
      hl = $urandom_range(0, 3);
      hr = 12 - nrounds(m) + $urandom_range(0, nrounds(m) - 1);
      do_op(m, st, hr, hl, 1'b0, 1'b0);
      build_exp(m, hr, hl, 1'b0);
      checks++; d = first_diff(obs_c, exp_c);
      if (d >= 0) begin errors++; $display("FAIL rand_consts[%0d]: index %0d differs", i, d); end
      checks++;
      if (lat != nrounds(m) + 1 + hl) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, required %0d", i, lat, nrounds(m) + 1 + hl); end
      checks++;
      if (fin !== ref_final(m, st, 1'b0)) begin errors++; $display("FAIL rand_state[%0d]: got %h, required %h", i, fin, ref_final(m, st, 1'b0)); end
    end
  endtask

`ifdef CONST_ADD_BYPASS_EN
  task automatic test_bypass();
    int d;
    do_op(1'b0, '1, -1, 0, 1'b1, 1'b0);
    build_exp(1'b0, -1, 0, 1'b1);
    checks++; d = first_diff(obs_c, exp_c);
    if (d >= 0) begin errors++; $display("FAIL bypass_consts: index %0d differs", d); end
    checks++;
    if (fin !== '1 || lat != 13) begin errors++; $display("FAIL bypass_state: latency %0d state %h, required 13 / all ones", lat, fin); end
    bypass_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pa();
    test_pb();
    test_hold();
    test_start_ignored();
    test_random();
`ifdef CONST_ADD_BYPASS_EN
    test_bypass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
